tick_period_monitor: RTL
========================

Name: tick_period_monitor

Overview:
- Receiving end of the periodic tick interface: consumes a single-cycle strobe from a tick generator, e.g. the 1 s end-of-count pulse.
- Measures clock cycles between consecutive strobes and checks each period against an expected value and tolerance.
- Flags a lost tick stream and keeps saturating error and wrapping tick counters.
- Used for self-checking of timebases in course-experiment designs.

Parameters:
- CNT_W, 27, width of the period counter and of period_out.
- CNT_MAX, 27'd50_000_000, expected period in sys_clk cycles (50 MHz crystal, 1 s).
- TOL, 27'd1000, allowed absolute deviation from CNT_MAX in cycles (inclusive).
- TIMEOUT, 27'd100_000_000, cycles without a tick before the stream is declared lost; must satisfy CNT_MAX+TOL < TIMEOUT < 2^CNT_W.

Ports:
- sys_clk  input  1  system clock, 50 MHz.
- sys_rst  input  1  synchronous reset, active-high.
- tick_in  input  1  single-cycle strobe from the tick source, synchronous to sys_clk.
- period_out  output  CNT_W  last measured period in cycles.
- period_vld  output  1  one-cycle pulse: period_out/period_ok updated.
- period_ok  output  1  last measured period within CNT_MAX±TOL.
- timeout  output  1  level: tick stream lost.
- tick_cnt  output  16  ticks received since reset, wraps 0xFFFF->0.
- err_cnt  output  8  out-of-tolerance periods plus timeouts, saturates at 255.

Behaviour:
- Single clock domain; all state changes on posedge sys_clk.
- Reset: sys_rst=1 sampled at an edge forces state IDLE, cnt=0, period_out=0, period_vld=0, period_ok=0, timeout=0, tick_cnt=0, err_cnt=0.
  - tick_in is ignored while sys_rst=1.
  - Reset mid-measurement discards the partial count.
- Period definition: ticks at cycles t0 and t1 give period = t1-t0. Back-to-back ticks give 1.
- Every accepted tick increments tick_cnt in all states.
- IDLE: no reference tick yet.
  - On tick_in: cnt<=1, go MEASURE. No period_vld.
- MEASURE: cnt increments by 1 each cycle.
  - On tick_in: next edge sets period_out<=cnt, period_vld<=1 for exactly one cycle, period_ok<=(|cnt-CNT_MAX|<=TOL), cnt<=1.
  - If not ok: err_cnt+1 (saturating).
  - Latency tick->period_vld: 1 cycle.
  - If cnt==TIMEOUT and no tick this cycle: go LOST, timeout<=1, err_cnt+1 (saturating), period_ok unchanged, cnt held.
  - Tick coincident with cnt==TIMEOUT: the tick wins and is measured as a normal period (out of tolerance, so counted as an error); no timeout.
- LOST: timeout=1; cnt frozen.
  - On tick_in: timeout<=0, cnt<=1, go MEASURE. This tick is a new reference: no period_vld, no error.
- Comparison arithmetic: unsigned, CNT_W+1 bits internally; no overflow because cnt <= TIMEOUT < 2^CNT_W.
- Wrap and saturation: tick_cnt wraps silently; err_cnt holds 255, and further errors are not counted.
- Outputs registered; no combinational path from tick_in to any output.

Test Plan (CNT_W=8, CNT_MAX=10, TOL=1, TIMEOUT=20):
- Reset then ticks at cycles 5, 15, 25 -> period_vld pulses at 16 and 26, period_out=10, period_ok=1, err_cnt=0, tick_cnt=3.
- Ticks at 5, 14, 26 (periods 9, 12) -> first ok=1, second ok=0; err_cnt=1.
- Tick at 5, then none -> timeout=1 from cycle 26, err_cnt=1. Tick at 40 -> timeout=0 at 41, no period_vld. Tick at 50 -> period_out=10, ok=1.
- Ticks at 5 and 6 -> period_out=1, ok=0. Tick exactly 20 cycles after previous -> period_out=20, ok=0, timeout stays 0.
- Assert sys_rst for one cycle 6 cycles after a tick, then tick 4 and 14 cycles after reset release -> first tick gives no period_vld; second gives period_out=10. Tick held during reset is not counted.
- Force 300 bad periods -> err_cnt stays 255. Send 65537 ticks -> tick_cnt=1.

Source files
------------

// File: rtl/tick_period_monitor.sv
// tick_period_monitor: measures the cycle distance between consecutive
// single-cycle tick strobes, checks it against CNT_MAX +/- TOL, flags a lost
// tick stream after TIMEOUT cycles, and keeps tick/error counters.
module tick_period_monitor #(
  parameter int unsigned      CNT_W   = 27,
  parameter logic [CNT_W-1:0] CNT_MAX = 27'd50_000_000,
  parameter logic [CNT_W-1:0] TOL     = 27'd1000,
  parameter logic [CNT_W-1:0] TIMEOUT = 27'd100_000_000
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             tick_in,
  output logic [CNT_W-1:0] period_out,
  output logic             period_vld,
  output logic             period_ok,
  output logic             timeout,
  output logic [15:0]      tick_cnt,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOST    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             vld_q, vld_d;
  logic             ok_q, ok_d;
  logic             timeout_q, timeout_d;
  logic [15:0]      tick_cnt_q, tick_cnt_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic             err_inc;
  logic [CNT_W:0]   cnt_x, max_x, diff;
  logic             in_tol;

  // Absolute deviation of the running count from the expected period.
  always_comb begin
    cnt_x  = {1'b0, cnt_q};
    max_x  = {1'b0, CNT_MAX};
    diff   = (cnt_x >= max_x) ? (cnt_x - max_x) : (max_x - cnt_x);
    in_tol = (diff <= {1'b0, TOL});
  end

  // Next-state logic for the measurement FSM and all registered outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    vld_d      = 1'b0;
    ok_d       = ok_q;
    timeout_d  = timeout_q;
    tick_cnt_d = tick_cnt_q;
    err_cnt_d  = err_cnt_q;
    err_inc    = 1'b0;

    if (tick_in) begin
      tick_cnt_d = tick_cnt_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (tick_in) begin
          cnt_d   = CNT_ONE;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        // A tick arriving on the TIMEOUT cycle is still measured as a period.
        if (tick_in) begin
          period_d = cnt_q;
          vld_d    = 1'b1;
          ok_d     = in_tol;
          cnt_d    = CNT_ONE;
          err_inc  = ~in_tol;
        end else if (cnt_q == TIMEOUT) begin
          state_d   = LOST;
          timeout_d = 1'b1;
          err_inc   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      LOST: begin
        if (tick_in) begin
          timeout_d = 1'b0;
          cnt_d     = CNT_ONE;
          state_d   = MEASURE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (err_inc && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      period_q   <= '0;
      vld_q      <= 1'b0;
      ok_q       <= 1'b0;
      timeout_q  <= 1'b0;
      tick_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      vld_q      <= vld_d;
      ok_q       <= ok_d;
      timeout_q  <= timeout_d;
      tick_cnt_q <= tick_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign period_out = period_q;
  assign period_vld = vld_q;
  assign period_ok  = ok_q;
  assign timeout    = timeout_q;
  assign tick_cnt   = tick_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule
